alarm_controller: RTL and testbench
===================================

Name: alarm_controller

Overview:
Sequences the 16-bit alarm-time register of the alarm clock. Collects four BCD digits (HHMM) from the keypad decoder in set mode, range-checks them, and issues a one-cycle load strobe plus data to the alarm register. Also compares the registered alarm time with the running clock time and drives the alarm sound output, with a stop input and an enable switch. Sits between the keypad decoder / time counter and the alarm register / display mux.

Parameters:
ENTRY_TIMEOUT, 5000, clk cycles of key inactivity in ENTRY before entry is aborted (≥2)
TO_W, 13, counter width; must hold ENTRY_TIMEOUT

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
set_alarm  in  1  level; held/pulsed high requests entry mode (edge-detected internally)
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  4  key value; 0-9 digits, 4'hA = clear, others ignored
current_time  in  16  running time, BCD HH:MM [15:12][11:8][7:4][3:0]
alarm_time  in  16  registered alarm time (from alarm register output)
alarm_on  in  1  alarm enable switch
stop_alarm  in  1  level; silences ringing alarm
new_alarm_time  out  16  staged digits, to alarm register data input
load_alarm  out  1  one-cycle load strobe to alarm register
entry_active  out  1  high in ENTRY/CHECK/LOAD (display shows new_alarm_time)
digit_count  out  3  digits entered so far, 0-4
entry_error  out  1  one-cycle pulse on rejected or timed-out entry
sound_alarm  out  1  alarm ringing

Behaviour:
- Reset: all outputs 0, state IDLE, new_alarm_time=16'h0000, ring latch clear, set_alarm and match edge detectors cleared.
- States: IDLE, ENTRY, CHECK, LOAD.
- IDLE: rising edge of set_alarm (registered compare, 1-cycle latency) -> ENTRY; clears new_alarm_time to 0, digit_count to 0, timeout counter to 0.
- ENTRY: key_valid with key_code 0-9: new_alarm_time <= {new_alarm_time[11:0], key_code}; digit_count+1; timeout counter cleared. When count reaches 4 (on 4th digit) -> CHECK next cycle.
- ENTRY: key_code 4'hA clears new_alarm_time and digit_count, stays in ENTRY. Codes B-F ignored (no shift, counter not cleared).
- ENTRY: timeout counter increments each cycle without valid key; at ENTRY_TIMEOUT-1 -> IDLE, entry_error pulses 1 cycle, no load.
- ENTRY: further set_alarm edges ignored.
- CHECK (1 cycle): valid iff hours tens ≤2, hours units ≤9 (≤3 if tens=2), min tens ≤5, min units ≤9. Valid -> LOAD; invalid -> IDLE with entry_error pulse.
- LOAD (1 cycle): load_alarm=1, new_alarm_time stable; then IDLE. Strobe to IDLE: exactly 1 cycle; 4th digit to load_alarm high: 2 cycles.
- new_alarm_time holds its last value in IDLE; digit_count resets to 0 on IDLE entry.
- key_valid in CHECK/LOAD/IDLE ignored.
- Match: match = alarm_on & (current_time == alarm_time), registered. sound_alarm sets on rising edge of match only (stop within the matching minute does not retrigger).
- sound_alarm clears when stop_alarm=1 or alarm_on=0; clear wins over simultaneous set.
- Ringing independent of entry FSM; a load during ringing does not clear sound_alarm.
- Reset mid-entry: immediate return to IDLE, no load_alarm pulse, staged digits lost.

Decomposition:
- Shared package alarm_pkg: state encoding constants (IDLE/ENTRY/CHECK/LOAD), KEY_CLEAR=4'hA, BCD limit constants (HR_TENS_MAX=2, MIN_TENS_MAX=5).
- One natural sub-module: bcd_time_check (combinational, 16-bit HHMM -> valid), reusable by the time-set path.

Test Plan:
- Reset, set_alarm edge, keys 0,7,3,0 -> load_alarm one pulse 2 cycles after 4th key, new_alarm_time=16'h0730, entry_error=0.
- Keys 2,5,0,0 -> entry_error pulse, no load_alarm, state IDLE; keys 2,3,5,9 -> loads 16'h2359.
- Keys 1,2, key A, keys 0,6,4,5 -> loads 16'h0645; key F mid-entry leaves digit_count unchanged.
- Enter ENTRY, 1 digit, then ENTRY_TIMEOUT idle cycles -> entry_error pulse, IDLE, no load; reset asserted after 3 digits -> no load, outputs 0.
- alarm_time=16'h0730, alarm_on=1, current_time 0729->0730 -> sound_alarm=1 next cycle; stop_alarm -> 0 and stays 0 while 0730 held; alarm_on=0 with match -> never rings.
- Ringing, stop_alarm and match rising edge in same cycle -> sound_alarm stays 0.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared constants and types for the alarm-time entry path and its BCD checker.
package alarm_pkg;

    // Entry sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_CHECK = 2'd2,
        ST_LOAD  = 2'd3
    } state_e;

    // Keypad code that wipes the staged digits
    localparam logic [3:0] KEY_CLEAR = 4'hA;

    // BCD range limits for an HH:MM time
    localparam logic [3:0] DIGIT_MAX          = 4'd9;
    localparam logic [3:0] HR_TENS_MAX        = 4'd2;
    localparam logic [3:0] HR_UNITS_MAX_AT_20 = 4'd3;
    localparam logic [3:0] MIN_TENS_MAX       = 4'd5;

    // A complete entry is four digits, HHMM
    localparam logic [2:0] NUM_DIGITS = 3'd4;

    // True for keypad codes 0-9
    function automatic logic is_digit(input logic [3:0] code);
        return code <= DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_time_check.sv
// Combinational range check of a BCD HH:MM word (00:00 .. 23:59).
module bcd_time_check
    import alarm_pkg::*;
(
    input  logic [15:0] hhmm,
    output logic        valid
);

    logic [3:0] hr_tens;
    logic [3:0] hr_units;
    logic [3:0] min_tens;
    logic [3:0] min_units;

    assign hr_tens   = hhmm[15:12];
    assign hr_units  = hhmm[11:8];
    assign min_tens  = hhmm[7:4];
    assign min_units = hhmm[3:0];

    // Hours 00-23 (units limited to 3 only in the twenties), minutes 00-59
    always_comb begin
        valid = (hr_tens   <= HR_TENS_MAX)
             && (hr_units  <= DIGIT_MAX)
             && ((hr_tens != HR_TENS_MAX) || (hr_units <= HR_UNITS_MAX_AT_20))
             && (min_tens  <= MIN_TENS_MAX)
             && (min_units <= DIGIT_MAX);
    end

endmodule

// File: rtl/alarm_controller.sv
// Alarm-time entry sequencer and alarm ringing control.
// Collects four keypad digits, range-checks them and strobes them into the
// alarm register; independently rings when the running time hits the alarm.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int unsigned ENTRY_TIMEOUT = 5000,
    parameter int unsigned TO_W          = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_alarm,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [15:0] current_time,
    input  logic [15:0] alarm_time,
    input  logic        alarm_on,
    input  logic        stop_alarm,
    output logic [15:0] new_alarm_time,
    output logic        load_alarm,
    output logic        entry_active,
    output logic [2:0]  digit_count,
    output logic        entry_error,
    output logic        sound_alarm
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ENTRY_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              set_q, set_d;
    logic [15:0]       new_time_q, new_time_d;
    logic [2:0]        digit_count_q, digit_count_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              load_q, load_d;
    logic              entry_active_q, entry_active_d;
    logic              entry_error_q, entry_error_d;
    logic              match_q, match_d;
    logic              sound_q, sound_d;

    logic              set_rise;
    logic              digit_key;
    logic              clear_key;
    logic              time_valid;

    bcd_time_check u_check (
        .hhmm  (new_time_q),
        .valid (time_valid)
    );

    assign set_d     = set_alarm;
    assign set_rise  = set_alarm & ~set_q;
    assign digit_key = key_valid & is_digit(key_code);
    assign clear_key = key_valid & (key_code == KEY_CLEAR);

    // Entry sequencer next state: digit staging, timeout, range check, load strobe
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d        = state_q;
        new_time_d     = new_time_q;
        digit_count_d  = digit_count_q;
        to_cnt_d       = to_cnt_q;
        load_d         = 1'b0;
        entry_error_d  = 1'b0;
        entry_active_d = entry_active_q;

        unique case (state_q)
            ST_IDLE: begin
                if (set_rise) begin
                    state_d        = ST_ENTRY;
                    new_time_d     = 16'h0000;
                    digit_count_d  = 3'd0;
                    to_cnt_d       = '0;
                    entry_active_d = 1'b1;
                end
            end
            ST_ENTRY: begin
                if (digit_key) begin
                    new_time_d    = {new_time_q[11:0], key_code};
                    digit_count_d = digit_count_q + 3'd1;
                    to_cnt_d      = '0;
                    if (digit_count_q == NUM_DIGITS - 3'd1) begin
                        state_d = ST_CHECK;
                    end
                end else if (clear_key) begin
                    new_time_d    = 16'h0000;
                    digit_count_d = 3'd0;
                    to_cnt_d      = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    // Keypad idle too long: abandon the entry without loading
                    state_d        = ST_IDLE;
                    entry_error_d  = 1'b1;
                    entry_active_d = 1'b0;
                    digit_count_d  = 3'd0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (time_valid) begin
                    state_d = ST_LOAD;
                    load_d  = 1'b1;
                end else begin
                    state_d        = ST_IDLE;
                    entry_error_d  = 1'b1;
                    entry_active_d = 1'b0;
                    digit_count_d  = 3'd0;
                end
            end
            ST_LOAD: begin
                state_d        = ST_IDLE;
                entry_active_d = 1'b0;
                digit_count_d  = 3'd0;
            end
            default: begin
                state_d        = ST_IDLE;
                entry_active_d = 1'b0;
                digit_count_d  = 3'd0;
            end
        endcase
    end

    // Ringing: set on the first cycle of a match, cleared by stop or disable (clear wins)
    always_comb begin
        match_d = alarm_on & (current_time == alarm_time);
        sound_d = sound_q;
        if (stop_alarm | ~alarm_on) begin
            sound_d = 1'b0;
        end else if (match_d & ~match_q) begin
            sound_d = 1'b1;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            set_q          <= 1'b0;
            new_time_q     <= 16'h0000;
            digit_count_q  <= 3'd0;
            to_cnt_q       <= '0;
            load_q         <= 1'b0;
            entry_active_q <= 1'b0;
            entry_error_q  <= 1'b0;
            match_q        <= 1'b0;
            sound_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q        <= state_d;
            set_q          <= set_d;
            new_time_q     <= new_time_d;
            digit_count_q  <= digit_count_d;
            to_cnt_q       <= to_cnt_d;
            load_q         <= load_d;
            entry_active_q <= entry_active_d;
            entry_error_q  <= entry_error_d;
            match_q        <= match_d;
            sound_q        <= sound_d;
        end
    end

    assign new_alarm_time = new_time_q;
    assign load_alarm     = load_q;
    assign entry_active   = entry_active_q;
    assign digit_count    = digit_count_q;
    assign entry_error    = entry_error_q;
    assign sound_alarm    = sound_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed and random keypad entries checked
// against a digit-list model, plus random ringing stimulus against a
// per-cycle model of the set/stop rules.
module tb_alarm_controller;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set_alarm = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [15:0] current_time = 16'h0000;
    logic [15:0] alarm_time = 16'h0000;
    logic        alarm_on = 1'b0;
    logic        stop_alarm = 1'b0;
    logic [15:0] new_alarm_time;
    logic        load_alarm;
    logic        entry_active;
    logic [2:0]  digit_count;
    logic        entry_error;
    logic        sound_alarm;

    int n_assert = 0;
    int n_fail = 0;
    int load_count = 0;
    int exp_loads = 0;
    int keys_q[$];

    alarm_controller #(.ENTRY_TIMEOUT(T), .TO_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .set_alarm      (set_alarm),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .current_time   (current_time),
        .alarm_time     (alarm_time),
        .alarm_on       (alarm_on),
        .stop_alarm     (stop_alarm),
        .new_alarm_time (new_alarm_time),
        .load_alarm     (load_alarm),
        .entry_active   (entry_active),
        .digit_count    (digit_count),
        .entry_error    (entry_error),
        .sound_alarm    (sound_alarm)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_alarm === 1'b1) load_count++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_key(input int k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'(k);
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic enter();
        @(negedge clk);
        set_alarm = 1'b1;
        @(negedge clk);
        check("enter_active", 32'(entry_active), 1);
        check("enter_count", 32'(digit_count), 0);
        check("enter_time", 32'(new_alarm_time), 0);
        set_alarm = 1'b0;
    endtask

    // Plays keys_q (ending on the fourth digit) and checks the outcome
    task automatic run_entry();
        int d[$];
        int v;
        bit ok;
        enter();
        foreach (keys_q[i]) begin
            send_key(keys_q[i]);
            if (keys_q[i] <= 9) d.push_back(keys_q[i]);
            else if (keys_q[i] == 10) d.delete();
            if (d.size() < 4) begin
                check("entry_count", 32'(digit_count), d.size());
                check("entry_still_active", 32'(entry_active), 1);
            end
        end
        v  = d[0] * 4096 + d[1] * 256 + d[2] * 16 + d[3];
        ok = (d[0] * 10 + d[1] < 24) && (d[2] < 6);
        check("check_count", 32'(digit_count), 4);
        check("check_time", 32'(new_alarm_time), v);
        check("check_no_load", 32'(load_alarm), 0);
        @(negedge clk);
        if (ok) begin
            exp_loads++;
            check("load_strobe", 32'(load_alarm), 1);
            check("load_data", 32'(new_alarm_time), v);
            check("load_no_error", 32'(entry_error), 0);
        end else begin
            check("reject_no_load", 32'(load_alarm), 0);
            check("reject_error", 32'(entry_error), 1);
            check("reject_idle", 32'(entry_active), 0);
        end
        @(negedge clk);
        check("after_load", 32'(load_alarm), 0);
        check("after_error", 32'(entry_error), 0);
        check("after_idle", 32'(entry_active), 0);
        check("after_count", 32'(digit_count), 0);
        check("after_hold", 32'(new_alarm_time), v);
        check("load_total", 32'(load_count), exp_loads);
    endtask

    task automatic set_keys(input int a, input int b, input int c, input int e);
        keys_q.delete();
        keys_q.push_back(a);
        keys_q.push_back(b);
        keys_q.push_back(c);
        keys_q.push_back(e);
    endtask

    initial begin
        int nd;
        int k;
        bit m_prev;
        bit m_ring;
        bit m;

        // Reset state
        @(negedge clk);
        check("rst_time", 32'(new_alarm_time), 0);
        check("rst_load", 32'(load_alarm), 0);
        check("rst_active", 32'(entry_active), 0);
        check("rst_count", 32'(digit_count), 0);
        check("rst_error", 32'(entry_error), 0);
        check("rst_sound", 32'(sound_alarm), 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed entries
        set_keys(0, 7, 3, 0); run_entry();
        set_keys(2, 5, 0, 0); run_entry();
        set_keys(2, 3, 5, 9); run_entry();
        keys_q = '{1, 2, 10, 0, 6, 15, 4, 5}; run_entry();
        check("load_0645", 32'(new_alarm_time), 32'h0645);

        // Random entries including clear and ignored codes
        for (int n = 0; n < 25; n++) begin
            keys_q.delete();
            nd = 0;
            while (nd < 4) begin
                k = $urandom_range(0, 19);
                if (k == 0) k = 10;
                else if (k == 1) k = $urandom_range(11, 15);
                else if (nd == 0) k = $urandom_range(0, 2);
                else if (nd == 2) k = $urandom_range(0, 7);
                else k = $urandom_range(0, 9);
                if (k <= 9) nd++;
                else if (k == 10) nd = 0;
                keys_q.push_back(k);
            end
            run_entry();
        end

        // Timeout after one digit
        enter();
        send_key(1);
        for (int i = 1; i < T; i++) @(negedge clk);
        check("to_not_yet", 32'(entry_error), 0);
        check("to_still_active", 32'(entry_active), 1);
        @(negedge clk);
        check("to_error", 32'(entry_error), 1);
        check("to_idle", 32'(entry_active), 0);
        check("to_count", 32'(digit_count), 0);
        @(negedge clk);
        check("to_error_pulse", 32'(entry_error), 0);
        check("to_no_load", 32'(load_count), exp_loads);

        // Reset in the middle of an entry
        enter();
        send_key(1);
        send_key(2);
        send_key(3);
        reset = 1'b1;
        #1;
        check("mid_rst_active", 32'(entry_active), 0);
        check("mid_rst_time", 32'(new_alarm_time), 0);
        check("mid_rst_count", 32'(digit_count), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_no_load", 32'(load_count), exp_loads);
        check("mid_rst_idle", 32'(entry_active), 0);

        // Ringing: directed
        alarm_time = 16'h0730;
        alarm_on = 1'b1;
        current_time = 16'h0729;
        @(negedge clk);
        check("ring_before", 32'(sound_alarm), 0);
        current_time = 16'h0730;
        @(negedge clk);
        check("ring_set", 32'(sound_alarm), 1);
        stop_alarm = 1'b1;
        @(negedge clk);
        check("ring_stop", 32'(sound_alarm), 0);
        stop_alarm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ring_no_retrigger", 32'(sound_alarm), 0);
        end
        current_time = 16'h0729;
        @(negedge clk);
        current_time = 16'h0730;
        @(negedge clk);
        check("ring_again", 32'(sound_alarm), 1);
        set_keys(1, 2, 0, 0); run_entry();
        check("ring_survives_load", 32'(sound_alarm), 1);
        stop_alarm = 1'b1;
        @(negedge clk);
        stop_alarm = 1'b0;
        alarm_on = 1'b0;
        current_time = 16'h0729;
        @(negedge clk);
        current_time = 16'h0730;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ring_disabled", 32'(sound_alarm), 0);
        end
        alarm_on = 1'b1;
        current_time = 16'h0729;
        @(negedge clk);
        current_time = 16'h0730;
        @(negedge clk);
        check("ring_third", 32'(sound_alarm), 1);
        current_time = 16'h0729;
        @(negedge clk);
        current_time = 16'h0730;
        stop_alarm = 1'b1;
        @(negedge clk);
        check("stop_beats_set", 32'(sound_alarm), 0);
        stop_alarm = 1'b0;
        @(negedge clk);
        check("stop_beats_set_hold", 32'(sound_alarm), 0);

        // Ringing: random against the set/stop rules
        alarm_on = 1'b0;
        @(negedge clk);
        m_prev = 1'b0;
        m_ring = 1'b0;
        for (int n = 0; n < 300; n++) begin
            alarm_on   = ($urandom_range(0, 7) != 0);
            stop_alarm = ($urandom_range(0, 9) == 0);
            current_time = ($urandom_range(0, 2) == 0) ? alarm_time : 16'($urandom_range(0, 16'h2359));
            @(negedge clk);
            m = alarm_on && (current_time == alarm_time);
            if (stop_alarm || !alarm_on) m_ring = 1'b0;
            else if (m && !m_prev) m_ring = 1'b1;
            m_prev = m;
            check("ring_random", 32'(sound_alarm), 32'(m_ring));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
